// File: rtl/mseq_pkg.sv
// Shared types and constants for the M-sequence reseed scheduler.
// The optional statistics counters are enabled by defining MSEQ_RESEED_STAT_EN.
package mseq_pkg;

    typedef enum logic [2:0] {
        RSD_WARMUP  = 3'd0,
        RSD_WAIT    = 3'd1,
        RSD_STARVED = 3'd2,
        RSD_ISSUE   = 3'd3,
        RSD_SETTLE  = 3'd4
    } mseq_rsd_state_t;

    localparam int unsigned MSEQ_CHAOS_W        = 32'd288;
    localparam int unsigned MSEQ_SETTLE_DEFAULT = 32'd4;
    localparam int unsigned MSEQ_ISSUE_CNT_W    = 32'd32;
    localparam int unsigned MSEQ_UNDERRUN_CNT_W = 32'd16;

endpackage

// File: rtl/mseq_word_buf.sv
// One-entry holding register for the chaotic word between the upstream
// handshake and the bank issue.
module mseq_word_buf
    import mseq_pkg::*;
#(
    parameter int unsigned W = MSEQ_CHAOS_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_fill,
    input  logic         i_drain,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty
);

    logic         r_full;
    logic [W-1:0] r_data;

    // Fill takes priority; the owner never fills and drains in one cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_full <= 1'b0;
            r_data <= {W{1'b0}};
        end else if (i_fill) begin
            r_full <= 1'b1;
            r_data <= i_din;
        end else if (i_drain) begin
            r_full <= 1'b0;
        end else begin
            r_full <= r_full;
        end
    end

    assign o_dout  = r_data;
    assign o_full  = r_full;
    assign o_empty = ~r_full;

endmodule

// File: rtl/mseq_reseed_ctrl.sv
// Reseed scheduler: buffers one chaotic word and issues it to the M-sequence
// bank at a programmable interval. Statistics counters exist only when
// MSEQ_RESEED_STAT_EN is defined.
module mseq_reseed_ctrl
    import mseq_pkg::*;
#(
    parameter int unsigned INPUT_DATA_WIDTH = MSEQ_CHAOS_W,
    parameter int unsigned PERIOD_WIDTH     = 32'd16,
    parameter int unsigned DEFAULT_PERIOD   = 32'd1024,
    parameter int unsigned WARMUP_CYCLES    = 32'd512,
    parameter int unsigned SETTLE_CYCLES    = MSEQ_SETTLE_DEFAULT
) (
    input  logic                        MSEQ_clk,
    input  logic                        MSEQ_rst,
    input  logic [INPUT_DATA_WIDTH-1:0] chaos_din,
    input  logic                        chaos_vld,
    output logic                        chaos_rdy,
    input  logic [PERIOD_WIDTH-1:0]     cfg_period,
    input  logic                        cfg_wr,
    input  logic                        cfg_force,
    input  logic                        cfg_clr,
    output logic [INPUT_DATA_WIDTH-1:0] MSEQ_din,
    output logic                        MSEQ_din_vld,
    output logic                        MSEQ_bank_rst_n,
    output logic                        reseed_busy,
    output logic                        underrun,
    output logic [MSEQ_ISSUE_CNT_W-1:0]    stat_issue_cnt,
    output logic [MSEQ_UNDERRUN_CNT_W-1:0] stat_underrun_cnt
);

    localparam int unsigned WU_W = $clog2(WARMUP_CYCLES + 32'd1);
    localparam int unsigned ST_W = $clog2(SETTLE_CYCLES + 32'd1);
    localparam logic [PERIOD_WIDTH-1:0] PER_ZERO = {PERIOD_WIDTH{1'b0}};
    localparam logic [PERIOD_WIDTH-1:0] PER_ONE  = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};

    mseq_rsd_state_t              r_state;
    logic [WU_W-1:0]              r_wu_cnt;
    logic [ST_W-1:0]              r_settle_cnt;
    logic [PERIOD_WIDTH-1:0]      r_period;
    logic [PERIOD_WIDTH-1:0]      r_per_cnt;
    logic [INPUT_DATA_WIDTH-1:0]  r_din;
    logic                         r_din_vld;
    logic                         r_bank_rst_n;
    logic                         r_busy;
    logic                         r_underrun;

    logic                         w_fill;
    logic                         w_drain;
    logic                         w_full;
    logic                         w_empty;
    logic                         w_rdy;
    logic                         w_expire;
    logic                         w_uf_set;
    logic [INPUT_DATA_WIDTH-1:0]  w_buf_dout;

    assign w_rdy    = w_empty & (r_state != RSD_WARMUP);
    assign w_fill   = chaos_vld & w_rdy;
    assign w_drain  = (r_state == RSD_ISSUE);
    assign w_expire = (r_per_cnt == PER_ZERO) | cfg_force;
    assign w_uf_set = (r_state == RSD_WAIT) & w_expire & w_empty;

    mseq_word_buf #(.W(INPUT_DATA_WIDTH)) u_word_buf (
        .i_clk   (MSEQ_clk),
        .i_rst   (MSEQ_rst),
        .i_fill  (w_fill),
        .i_drain (w_drain),
        .i_din   (chaos_din),
        .o_dout  (w_buf_dout),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Period register; zero would stall the countdown so it is stored as one.
    always_ff @(posedge MSEQ_clk) begin
        if (MSEQ_rst) begin
            r_period <= PERIOD_WIDTH'(DEFAULT_PERIOD);
        end else if (cfg_wr) begin
            r_period <= (cfg_period == PER_ZERO) ? PER_ONE : cfg_period;
        end else begin
            r_period <= r_period;
        end
    end

    // Scheduler FSM; the countdown is loaded with P-1 so WAIT spans P cycles.
    always_ff @(posedge MSEQ_clk) begin
        if (MSEQ_rst) begin
            r_state      <= RSD_WARMUP;
            r_wu_cnt     <= {WU_W{1'b0}};
            r_settle_cnt <= {ST_W{1'b0}};
            r_per_cnt    <= PER_ZERO;
            r_din        <= {INPUT_DATA_WIDTH{1'b0}};
            r_din_vld    <= 1'b0;
            r_bank_rst_n <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_din_vld <= 1'b0;
            case (r_state)
                RSD_WARMUP: begin
                    r_wu_cnt <= r_wu_cnt + {{(WU_W-1){1'b0}}, 1'b1};
                    if (r_wu_cnt == WU_W'(WARMUP_CYCLES - 32'd1)) begin
                        r_state      <= RSD_WAIT;
                        r_bank_rst_n <= 1'b1;
                        r_per_cnt    <= r_period - PER_ONE;
                    end
                end
                RSD_WAIT: begin
                    if (w_expire) begin
                        if (w_full) begin
                            r_state   <= RSD_ISSUE;
                            r_din     <= w_buf_dout;
                            r_din_vld <= 1'b1;
                            r_busy    <= 1'b1;
                        end else begin
                            r_state <= RSD_STARVED;
                        end
                    end else begin
                        r_per_cnt <= r_per_cnt - PER_ONE;
                    end
                end
                RSD_STARVED: begin
                    if (w_full) begin
                        r_state   <= RSD_ISSUE;
                        r_din     <= w_buf_dout;
                        r_din_vld <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                RSD_ISSUE: begin
                    r_state      <= RSD_SETTLE;
                    r_settle_cnt <= {ST_W{1'b0}};
                end
                RSD_SETTLE: begin
                    if (r_settle_cnt == ST_W'(SETTLE_CYCLES - 32'd1)) begin
                        r_state   <= RSD_WAIT;
                        r_busy    <= 1'b0;
                        r_per_cnt <= r_period - PER_ONE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + {{(ST_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    r_state <= RSD_WARMUP;
                end
            endcase
        end
    end

    // Sticky underrun flag; a set in the same cycle as a clear wins.
    always_ff @(posedge MSEQ_clk) begin
        if (MSEQ_rst) begin
            r_underrun <= 1'b0;
        end else if (w_uf_set) begin
            r_underrun <= 1'b1;
        end else if (cfg_clr) begin
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= r_underrun;
        end
    end

`ifdef MSEQ_RESEED_STAT_EN
    logic [MSEQ_ISSUE_CNT_W-1:0]    r_issue_cnt;
    logic [MSEQ_UNDERRUN_CNT_W-1:0] r_uf_cnt;

    // Saturating counters; an increment alongside a clear restarts at one.
    always_ff @(posedge MSEQ_clk) begin
        if (MSEQ_rst) begin
            r_issue_cnt <= {MSEQ_ISSUE_CNT_W{1'b0}};
            r_uf_cnt    <= {MSEQ_UNDERRUN_CNT_W{1'b0}};
        end else begin
            if (w_drain) begin
                r_issue_cnt <= cfg_clr ? MSEQ_ISSUE_CNT_W'(1) :
                               (&r_issue_cnt) ? r_issue_cnt : r_issue_cnt + MSEQ_ISSUE_CNT_W'(1);
            end else if (cfg_clr) begin
                r_issue_cnt <= {MSEQ_ISSUE_CNT_W{1'b0}};
            end else begin
                r_issue_cnt <= r_issue_cnt;
            end
            if (w_uf_set) begin
                r_uf_cnt <= cfg_clr ? MSEQ_UNDERRUN_CNT_W'(1) :
                            (&r_uf_cnt) ? r_uf_cnt : r_uf_cnt + MSEQ_UNDERRUN_CNT_W'(1);
            end else if (cfg_clr) begin
                r_uf_cnt <= {MSEQ_UNDERRUN_CNT_W{1'b0}};
            end else begin
                r_uf_cnt <= r_uf_cnt;
            end
        end
    end

    assign stat_issue_cnt    = r_issue_cnt;
    assign stat_underrun_cnt = r_uf_cnt;
`else
    assign stat_issue_cnt    = {MSEQ_ISSUE_CNT_W{1'b0}};
    assign stat_underrun_cnt = {MSEQ_UNDERRUN_CNT_W{1'b0}};
`endif

    assign chaos_rdy       = w_rdy;
    assign MSEQ_din        = r_din;
    assign MSEQ_din_vld    = r_din_vld;
    assign MSEQ_bank_rst_n = r_bank_rst_n;
    assign reseed_busy     = r_busy;
    assign underrun        = r_underrun;

endmodule

// File: tb/tb_mseq_reseed_ctrl.sv
// Directed/randomized bench for mseq_reseed_ctrl; issue times and words are
// predicted from the scheduling rules (warm-up, period, settle, starvation).
module tb_mseq_reseed_ctrl;

    localparam int W   = 288;
    localparam int PW  = 16;
    localparam int WU  = 8;
    localparam int PER = 10;
    localparam int ST  = 4;
`ifdef MSEQ_RESEED_STAT_EN
    localparam bit STAT_EN = 1'b1;
`else
    localparam bit STAT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          MSEQ_rst;
    logic [W-1:0]  chaos_din;
    logic          chaos_vld;
    logic          chaos_rdy;
    logic [PW-1:0] cfg_period;
    logic          cfg_wr;
    logic          cfg_force;
    logic          cfg_clr;
    logic [W-1:0]  MSEQ_din;
    logic          MSEQ_din_vld;
    logic          MSEQ_bank_rst_n;
    logic          reseed_busy;
    logic          underrun;
    logic [31:0]   stat_issue_cnt;
    logic [15:0]   stat_underrun_cnt;

    always #5 clk = ~clk;

    mseq_reseed_ctrl #(
        .INPUT_DATA_WIDTH (W),
        .PERIOD_WIDTH     (PW),
        .DEFAULT_PERIOD   (PER),
        .WARMUP_CYCLES    (WU),
        .SETTLE_CYCLES    (ST)
    ) dut (
        .MSEQ_clk          (clk),
        .MSEQ_rst          (MSEQ_rst),
        .chaos_din         (chaos_din),
        .chaos_vld         (chaos_vld),
        .chaos_rdy         (chaos_rdy),
        .cfg_period        (cfg_period),
        .cfg_wr            (cfg_wr),
        .cfg_force         (cfg_force),
        .cfg_clr           (cfg_clr),
        .MSEQ_din          (MSEQ_din),
        .MSEQ_din_vld      (MSEQ_din_vld),
        .MSEQ_bank_rst_n   (MSEQ_bank_rst_n),
        .reseed_busy       (reseed_busy),
        .underrun          (underrun),
        .stat_issue_cnt    (stat_issue_cnt),
        .stat_underrun_cnt (stat_underrun_cnt)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int fi       = 0;
    int exp_word = 0;
    logic [W-1:0] words [0:15];
    int           obs_cyc [$];
    logic [W-1:0] obs_dat [$];
    int           exp_cyc [$];
    logic [W-1:0] exp_dat [$];

    function automatic int exp_stat(input int v);
        return STAT_EN ? v : 0;
    endfunction

    task automatic chk_w(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: the feeder advances on an accepted word, issues are logged.
    task automatic tick();
        bit hs;
        hs = (chaos_vld === 1'b1) && (chaos_rdy === 1'b1);
        @(posedge clk);
        #1;
        cyc++;
        if (hs) begin
            fi++;
            chaos_din = words[fi];
        end
        if (MSEQ_din_vld === 1'b1) begin
            obs_cyc.push_back(cyc);
            obs_dat.push_back(MSEQ_din);
        end
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic expect_issue(input int c);
        exp_cyc.push_back(c);
        exp_dat.push_back(words[exp_word]);
        exp_word++;
    endtask

    task automatic check_issues(input string tag);
        int n;
        chk_i({tag, "_count"}, obs_cyc.size(), exp_cyc.size());
        n = (obs_cyc.size() < exp_cyc.size()) ? obs_cyc.size() : exp_cyc.size();
        for (int i = 0; i < n; i++) begin
            chk_i($sformatf("%s_cyc%0d", tag, i), obs_cyc[i], exp_cyc[i]);
            chk_w($sformatf("%s_dat%0d", tag, i), obs_dat[i], exp_dat[i]);
        end
        obs_cyc.delete();
        obs_dat.delete();
        exp_cyc.delete();
        exp_dat.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk_b({tag, "_din_vld"}, MSEQ_din_vld, 1'b0);
        chk_w({tag, "_din"}, MSEQ_din, {W{1'b0}});
        chk_b({tag, "_bank_rst_n"}, MSEQ_bank_rst_n, 1'b0);
        chk_b({tag, "_busy"}, reseed_busy, 1'b0);
        chk_b({tag, "_underrun"}, underrun, 1'b0);
        chk_b({tag, "_rdy"}, chaos_rdy, 1'b0);
        chk_i({tag, "_issue_cnt"}, int'(stat_issue_cnt), 0);
        chk_i({tag, "_uf_cnt"}, int'(stat_underrun_cnt), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int vc;
        int fc;
        int wc;

        words[0] = {36{8'hA5}};
        words[1] = {36{8'h5A}};
        for (int i = 2; i < 16; i++) begin
            for (int j = 0; j < 9; j++) words[i][j*32 +: 32] = $urandom();
        end
        MSEQ_rst   = 1'b1;
        chaos_din  = words[0];
        chaos_vld  = 1'b0;
        cfg_period = '0;
        cfg_wr     = 1'b0;
        cfg_force  = 1'b0;
        cfg_clr    = 1'b0;
        tick(); tick(); tick();

        // Cycle 0: first cycle with reset released.
        MSEQ_rst  = 1'b0;
        cyc       = 0;
        chaos_vld = 1'b1;
        chk_all_zero("reset");

        run_to(WU - 1);
        chk_b("wu_bank_rst_n_low", MSEQ_bank_rst_n, 1'b0);
        chk_b("wu_rdy_low", chaos_rdy, 1'b0);
        run_to(WU);
        chk_b("wu_bank_rst_n_high", MSEQ_bank_rst_n, 1'b1);
        chk_b("wait_rdy_high", chaos_rdy, 1'b1);

        // Steady state: first issue after WU+P, then every ST+1+P.
        t = WU + PER;
        expect_issue(t);
        t = t + ST + 1 + PER;
        expect_issue(t);
        t = t + ST + 1 + PER;
        expect_issue(t);
        run_to(t + 1);
        chk_b("settle_busy", reseed_busy, 1'b1);
        chk_i("steady_issue_cnt", int'(stat_issue_cnt), exp_stat(3));
        check_issues("steady");

        // Underrun: source goes idle before the buffer reopens.
        chaos_vld = 1'b0;
        run_to(t + ST + PER + 1);
        chk_b("uf_flag_set", underrun, 1'b1);
        chk_i("uf_cnt_one", int'(stat_underrun_cnt), exp_stat(1));
        vc = t + ST + PER + 6;
        run_to(vc);
        chaos_vld = 1'b1;
        expect_issue(vc + 2);
        run_to(vc + 1);
        chk_b("starved_flag_sticky", underrun, 1'b1);
        chk_i("starved_no_extra_count", int'(stat_underrun_cnt), exp_stat(1));
        t = vc + 2;
        run_to(t + 2);
        cfg_clr = 1'b1;
        tick();
        cfg_clr = 1'b0;
        chk_b("clr_flag", underrun, 1'b0);
        chk_i("clr_uf_cnt", int'(stat_underrun_cnt), 0);
        chk_i("clr_issue_cnt", int'(stat_issue_cnt), 0);
        check_issues("starved");

        // Forced reseed three cycles into WAIT, then an ignored force in SETTLE.
        fc = t + ST + 1 + 3;
        run_to(fc);
        chk_b("wait_not_busy", reseed_busy, 1'b0);
        cfg_force = 1'b1;
        tick();
        cfg_force = 1'b0;
        expect_issue(fc + 1);
        t = fc + 1;
        chk_b("issue_rdy_low", chaos_rdy, 1'b0);
        chk_b("issue_busy", reseed_busy, 1'b1);
        tick();
        chk_b("settle_rdy_high", chaos_rdy, 1'b1);
        run_to(t + 2);
        cfg_force = 1'b1;
        tick();
        cfg_force = 1'b0;
        chk_i("force_issue_cnt", int'(stat_issue_cnt), exp_stat(1));
        t = t + ST + 1 + PER;
        expect_issue(t);
        run_to(t);
        cfg_clr = 1'b1;
        tick();
        cfg_clr = 1'b0;
        chk_i("clr_vs_inc_issue_cnt", int'(stat_issue_cnt), exp_stat(1));
        check_issues("force");

        // Period write of zero mid-WAIT: current interval kept, then P=1.
        wc = t + ST + 1 + 3;
        run_to(wc);
        cfg_period = '0;
        cfg_wr     = 1'b1;
        tick();
        cfg_wr = 1'b0;
        t = t + ST + 1 + PER;
        expect_issue(t);
        for (int k = 0; k < 3; k++) begin
            t = t + ST + 1 + 1;
            expect_issue(t);
        end
        run_to(t + 1);
        chk_i("period_issue_cnt", int'(stat_issue_cnt), exp_stat(5));
        chk_w("din_hold", MSEQ_din, words[exp_word - 1]);
        check_issues("period");

        // Reset in SETTLE with a word buffered: that word must never issue.
        run_to(t + 3);
        chk_b("pre_reset_buf_full", chaos_rdy, 1'b0);
        MSEQ_rst = 1'b1;
        tick();
        chk_all_zero("midrst");
        MSEQ_rst = 1'b0;
        cyc      = 0;
        exp_word++;
        expect_issue(WU + PER);
        run_to(WU + PER + 1);
        check_issues("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
